// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle mul/div occupancy,
// taken-branch squash and JAL fetch flush, plus a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_md,
  input  logic        id_jal,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        busy,
  output logic [15:0] stall_count
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // The md instruction itself occupies the first EX cycle, so the counter
  // only has to cover the remaining MD_LAT-1 stall cycles (down to zero).
  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 2);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_md_cnt;
  logic [3:0]  w_next_cnt;
  logic [15:0] r_stall_count;
  logic        w_load_use;

  assign w_load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_md_cnt      <= 4'd0;
      r_stall_count <= 16'd0;
    end else begin
      r_state  <= w_next_state;
      r_md_cnt <= w_next_cnt;
      if (!pc_write && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  // Branch squash outranks everything, including an in-flight mul/div.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_md_cnt;
    if (rst) begin
      w_next_state = RUN;
      w_next_cnt   = 4'd0;
    end else if (ex_branch_taken) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      w_next_state = RUN;
      w_next_cnt   = 4'd0;
    end else if (r_state == MD_BUSY) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (r_md_cnt == 4'd0)
        w_next_state = RUN;
      else
        w_next_cnt = r_md_cnt - 4'd1;
    end else if (w_load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_md) begin
      w_next_state = MD_BUSY;
      w_next_cnt   = MD_INIT;
    end else if (id_jal) begin
      ifid_flush = 1'b1;
    end
  end

  assign busy        = (r_state == MD_BUSY) && !rst;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each row pushes its expected outputs, which
// are popped and compared mid-cycle on the falling edge.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_md;
  logic        id_jal;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        busy;
  logic [15:0] stall_count;

  // ctrl packs the expected {pc_write, ifid_write, ifid_flush, idex_bubble, busy}
  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       md;
    logic       jal;
    logic       memread;
    logic [4:0] exRt;
    logic       br;
    logic [4:0] ctrl;
  } row_t;

  logic [20:0] sb[$];
  logic [15:0] expSc;
  logic [20:0] expV;
  logic [20:0] gotV;
  int          nChecks;
  int          nFails;

  hazard_ctrl #(.MD_LAT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_md           (id_md),
    .id_jal          (id_jal),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .busy            (busy),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                              input logic ur, input logic md, input logic jal,
                              input logic mr, input logic [4:0] er, input logic br,
                              input logic [4:0] ctrl);
    row_t x;
    x.rst = r; x.rs = rs; x.rt = rt; x.usesRt = ur; x.md = md; x.jal = jal;
    x.memread = mr; x.exRt = er; x.br = br; x.ctrl = ctrl;
    return x;
  endfunction

  // Drives one cycle of inputs and records what the outputs must be; the
  // expected stall count follows from the expected pc_write of earlier rows.
  task automatic drive(input row_t r);
    rst = r.rst; id_rs = r.rs; id_rt = r.rt; id_uses_rt = r.usesRt;
    id_md = r.md; id_jal = r.jal; ex_memread = r.memread; ex_rt = r.exRt;
    ex_branch_taken = r.br;
    sb.push_back({r.ctrl, expSc});
    if (r.rst) expSc = 16'd0;
    else if (!r.ctrl[4] && expSc != 16'hFFFF) expSc = expSc + 16'd1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    rows = '{mk(1, 5'd8, 5'd8, 1, 1, 1, 1, 5'd8, 1, 5'b11000),
             mk(1, 5'd3, 5'd4, 0, 1, 0, 1, 5'd3, 0, 5'b11000)};
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      expV = sb.pop_front();
      gotV = {pc_write, ifid_write, ifid_flush, idex_bubble, busy, stall_count};
      nChecks++;
      if (gotV !== expV) begin
        nFails++;
        $display("[TB] FAIL reset row %0d: ctrl/count got %b/%0d expected %b/%0d",
                 k, gotV[20:16], gotV[15:0], expV[20:16], expV[15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_normal();
    row_t rows[$];
    rows = '{mk(0, 5'd1, 5'd2, 1, 0, 0, 0, 5'd0, 0, 5'b11000),
             mk(0, 5'd9, 5'd8, 0, 0, 0, 1, 5'd8, 0, 5'b11000),
             mk(0, 5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, 5'b11000)};
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      expV = sb.pop_front();
      gotV = {pc_write, ifid_write, ifid_flush, idex_bubble, busy, stall_count};
      nChecks++;
      if (gotV !== expV) begin
        nFails++;
        $display("[TB] FAIL normal row %0d: ctrl/count got %b/%0d expected %b/%0d",
                 k, gotV[20:16], gotV[15:0], expV[20:16], expV[15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    rows = '{mk(0, 5'd8, 5'd1, 0, 0, 0, 1, 5'd8, 0, 5'b00010),
             mk(0, 5'd8, 5'd1, 0, 0, 0, 0, 5'd8, 0, 5'b11000),
             mk(0, 5'd3, 5'd5, 1, 0, 0, 1, 5'd5, 0, 5'b00010),
             mk(0, 5'd3, 5'd5, 0, 0, 0, 1, 5'd5, 0, 5'b11000)};
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      expV = sb.pop_front();
      gotV = {pc_write, ifid_write, ifid_flush, idex_bubble, busy, stall_count};
      nChecks++;
      if (gotV !== expV) begin
        nFails++;
        $display("[TB] FAIL load_use row %0d: ctrl/count got %b/%0d expected %b/%0d",
                 k, gotV[20:16], gotV[15:0], expV[20:16], expV[15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_md();
    row_t rows[$];
    rows = '{mk(0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 0, 5'b11000),
             mk(0, 5'd1, 5'd2, 1, 0, 0, 0, 5'd0, 0, 5'b00011),
             mk(0, 5'd1, 5'd2, 1, 0, 1, 0, 5'd0, 0, 5'b00011),
             mk(0, 5'd7, 5'd2, 1, 1, 0, 1, 5'd7, 0, 5'b00011),
             mk(0, 5'd1, 5'd2, 1, 0, 0, 0, 5'd0, 0, 5'b11000)};
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      expV = sb.pop_front();
      gotV = {pc_write, ifid_write, ifid_flush, idex_bubble, busy, stall_count};
      nChecks++;
      if (gotV !== expV) begin
        nFails++;
        $display("[TB] FAIL md_busy row %0d: ctrl/count got %b/%0d expected %b/%0d",
                 k, gotV[20:16], gotV[15:0], expV[20:16], expV[15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_in_busy();
    row_t rows[$];
    rows = '{mk(0, 5'd1, 5'd2, 0, 1, 0, 0, 5'd0, 0, 5'b11000),
             mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 5'b00011),
             mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 1, 5'b11111),
             mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 5'b11000)};
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      expV = sb.pop_front();
      gotV = {pc_write, ifid_write, ifid_flush, idex_bubble, busy, stall_count};
      nChecks++;
      if (gotV !== expV) begin
        nFails++;
        $display("[TB] FAIL branch_busy row %0d: ctrl/count got %b/%0d expected %b/%0d",
                 k, gotV[20:16], gotV[15:0], expV[20:16], expV[15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    row_t rows[$];
    rows = '{mk(0, 5'd6, 5'd1, 0, 0, 1, 1, 5'd6, 0, 5'b00010),
             mk(0, 5'd6, 5'd1, 0, 0, 1, 0, 5'd6, 0, 5'b11100),
             mk(0, 5'd4, 5'd1, 0, 1, 0, 1, 5'd4, 0, 5'b00010),
             mk(0, 5'd4, 5'd1, 0, 1, 0, 0, 5'd4, 0, 5'b11000),
             mk(0, 5'd4, 5'd1, 0, 0, 0, 0, 5'd0, 0, 5'b00011),
             mk(0, 5'd4, 5'd1, 0, 0, 0, 0, 5'd0, 0, 5'b00011),
             mk(0, 5'd4, 5'd1, 0, 0, 0, 0, 5'd0, 0, 5'b00011),
             mk(0, 5'd4, 5'd1, 0, 0, 0, 0, 5'd0, 0, 5'b11000),
             mk(0, 5'd2, 5'd1, 0, 1, 1, 1, 5'd2, 1, 5'b11110),
             mk(0, 5'd2, 5'd1, 0, 0, 0, 0, 5'd0, 0, 5'b11000)};
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      expV = sb.pop_front();
      gotV = {pc_write, ifid_write, ifid_flush, idex_bubble, busy, stall_count};
      nChecks++;
      if (gotV !== expV) begin
        nFails++;
        $display("[TB] FAIL priority row %0d: ctrl/count got %b/%0d expected %b/%0d",
                 k, gotV[20:16], gotV[15:0], expV[20:16], expV[15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_busy();
    row_t rows[$];
    rows = '{mk(0, 5'd1, 5'd2, 0, 1, 0, 0, 5'd0, 0, 5'b11000),
             mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 5'b00011),
             mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 5'b00011),
             mk(1, 5'd1, 5'd2, 0, 1, 0, 0, 5'd0, 0, 5'b11000),
             mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 5'b11000),
             mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 5'b11000)};
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      expV = sb.pop_front();
      gotV = {pc_write, ifid_write, ifid_flush, idex_bubble, busy, stall_count};
      nChecks++;
      if (gotV !== expV) begin
        nFails++;
        $display("[TB] FAIL reset_mid_busy row %0d: ctrl/count got %b/%0d expected %b/%0d",
                 k, gotV[20:16], gotV[15:0], expV[20:16], expV[15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    rows = '{mk(0, 5'd9, 5'd1, 0, 0, 0, 1, 5'd9, 0, 5'b00010),
             mk(0, 5'd2, 5'd9, 1, 0, 0, 1, 5'd9, 0, 5'b00010),
             mk(0, 5'd2, 5'd1, 0, 1, 0, 0, 5'd0, 0, 5'b11000),
             mk(0, 5'd2, 5'd1, 0, 0, 0, 0, 5'd0, 0, 5'b00011),
             mk(0, 5'd2, 5'd1, 0, 0, 0, 0, 5'd0, 0, 5'b00011),
             mk(0, 5'd2, 5'd1, 0, 1, 0, 0, 5'd0, 0, 5'b00011),
             mk(0, 5'd2, 5'd1, 0, 1, 0, 0, 5'd0, 0, 5'b11000),
             mk(0, 5'd2, 5'd1, 0, 0, 0, 0, 5'd0, 0, 5'b00011),
             mk(0, 5'd2, 5'd1, 0, 0, 0, 0, 5'd0, 0, 5'b00011),
             mk(0, 5'd2, 5'd1, 0, 0, 0, 0, 5'd0, 0, 5'b00011),
             mk(0, 5'd2, 5'd1, 0, 0, 0, 0, 5'd0, 0, 5'b11000)};
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      expV = sb.pop_front();
      gotV = {pc_write, ifid_write, ifid_flush, idex_bubble, busy, stall_count};
      nChecks++;
      if (gotV !== expV) begin
        nFails++;
        $display("[TB] FAIL back_to_back row %0d: ctrl/count got %b/%0d expected %b/%0d",
                 k, gotV[20:16], gotV[15:0], expV[20:16], expV[15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    expSc   = 16'd0;
    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_md = 1'b0;
    id_jal = 1'b0; ex_memread = 1'b0; ex_rt = '0; ex_branch_taken = 1'b0;
    @(posedge clk); #1;
    $display("[TB] starting hazard_ctrl scenarios");
    test_reset();
    test_normal();
    test_load_use();
    test_md();
    test_branch_in_busy();
    test_priority();
    test_reset_mid_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 4, meaning multi-cycle (mul/div) EX occupancy in cycles; legal range 2..15.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 id_rs  input  5  rs field of instruction in ID.
REQ-005 id_rt  input  5  rt field of instruction in ID.
REQ-006 id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-007 id_md  input  1  ID instruction is multi-cycle mul/div.
REQ-008 id_jal  input  1  ID instruction is JAL (target resolved in ID).
REQ-009 ex_memread  input  1  MemRead bit of ID/EX MEM control field (load in EX).
REQ-010 ex_rt  input  5  rt destination held in ID/EX.
REQ-011 ex_branch_taken  input  1  branch in EX resolved taken.
REQ-012 pc_write  output  1  PC update enable.
REQ-013 ifid_write  output  1  IF/ID register load enable.
REQ-014 ifid_flush  output  1  IF/ID contents replaced by NOP.
REQ-015 idex_bubble  output  1  zero WB/MEM/EX/Jal control fields entering ID/EX.
REQ-016 busy  output  1  high while in MD_BUSY.
REQ-017 stall_count  output  16  saturating count of cycles with pc_write=0.

Function
REQ-018 States: RUN, MD_BUSY; 4-bit down-counter md_cnt.
REQ-019 Outputs combinational from state and inputs; state, md_cnt, stall_count registered.
REQ-020 load_use = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))).
REQ-021 Priority, highest first: ex_branch_taken, MD_BUSY hold, load_use, id_md start, id_jal.
REQ-022 ex_branch_taken=1, any state: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1; next state RUN, md_cnt<=0.
REQ-023 MD_BUSY, no branch: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; md_cnt decrements each cycle.
REQ-024 MD_BUSY with md_cnt==0: final stall cycle; next state RUN.
REQ-025 RUN with load_use: pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle; state stays RUN.
REQ-026 RUN, id_md=1, no load_use: md instruction advances normally this cycle (all enables 1, no bubble); next state MD_BUSY, md_cnt<=MD_LAT-2; ID then stalls MD_LAT-1 cycles.
REQ-027 RUN, id_jal=1, no higher-priority event: ifid_flush=1, pc_write=1, ifid_write=1, idex_bubble=0.
REQ-028 RUN, no event: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-029 load_use and id_md together: load_use wins; id_md re-evaluated next cycle.
REQ-030 ifid_flush and ifid_write both 1: flush dominates (IF/ID gets NOP).
REQ-031 stall_count increments on every cycle with pc_write=0; holds at 16'hFFFF.
REQ-032 busy=1 iff state==MD_BUSY.

Reset
REQ-033 rst=1 at posedge: state<=RUN, md_cnt<=0, stall_count<=0, regardless of state or other inputs.
REQ-034 While rst=1: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, busy=0.
REQ-035 Reset during MD_BUSY aborts the stall; first cycle after rst deasserts behaves as RUN.

Verification
REQ-036 ex_memread=1, ex_rt=8, id_rs=8 one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle only; stall_count=1.
REQ-037 ex_memread=1, ex_rt=0, id_rs=0 -> no stall; all enables 1, stall_count unchanged.
REQ-038 MD_LAT=4, id_md=1 one cycle in RUN -> next 3 cycles busy=1, pc_write=0, idex_bubble=1; 4th cycle RUN, stall_count=3.
REQ-039 ex_branch_taken=1 on 2nd MD_BUSY cycle -> ifid_flush=1, idex_bubble=1 that cycle; next cycle RUN, busy=0.
REQ-040 id_jal=1 with load_use=1 -> stall only (ifid_flush=0); next cycle, id_jal still 1, load_use=0 -> ifid_flush=1.
REQ-041 rst=1 mid MD_BUSY, stall_count=5 -> next cycle state RUN, stall_count=0, all enables 1.
